// File: rtl/div_clk_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Used by div_clk_ratio_cnt and div_clk_prog.
package div_clk_pkg;

  localparam int DIV_MIN   = 2;
  localparam int CNT_W_DEF = 8;

  // High-phase length in clk cycles: ceil(n/2), computed without wrap
  function automatic logic [31:0] half_ceil(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/div_clk_ratio_cnt.sv
// Period counter: produces the posedge phase flop q_p and div_tick.
// A boundary is the last cycle of a period (cnt == cur_div-1).
module div_clk_ratio_cnt
  import div_clk_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cur_div,
  output logic             boundary,
  output logic             q_p,
  output logic             div_tick
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RCNT = CNT_W'(DIV_DEFAULT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_p_q, q_p_d;
  logic             tick_q, tick_d;

  assign boundary = (cnt_q == cur_div - ONE);
  assign q_p      = q_p_q;
  assign div_tick = tick_q;

  // Next count, phase and period-start pulse
  always_comb begin
    cnt_d  = boundary ? '0 : cnt_q + ONE;
    q_p_d  = 32'(cnt_d) < half_ceil(32'(cur_div));
    tick_d = (cnt_d == '0);
  end

  // Counter state; reset parks on the boundary so release starts a period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= RCNT;
      q_p_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_p_q  <= q_p_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/div_clk_prog.sv
// Runtime-programmable clock divider, f(clk)/N with valid/ready config.
// Define DIV_CLK_PROG_ODD_DUTY50_EN for 50% duty on odd N (negedge stage).
module div_clk_prog
  import div_clk_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             div_tick,
  output logic             div_clk
);

  localparam logic [CNT_W-1:0] RDIV = CNT_W'(DIV_DEFAULT);

  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic             boundary;
  logic             q_p;

  div_clk_ratio_cnt #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .cur_div (cur_div_q),
    .boundary(boundary),
    .q_p     (q_p),
    .div_tick(div_tick)
  );

  assign cfg_ready = ~pending_q;
  assign cfg_err   = cfg_err_q;
  assign cur_div   = cur_div_q;

  // Apply a pending divisor at a boundary, then take a new offer
  always_comb begin
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    cfg_err_d  = 1'b0;
    if (boundary && pending_q) begin
      cur_div_d = pend_div_q;
      pending_d = 1'b0;
    end
    if (cfg_valid && !pending_q) begin
      if (32'(cfg_div) < DIV_MIN) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_div_d = cfg_div;
        pending_d  = 1'b1;
      end
    end
  end

  // Config and divisor state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_div_q  <= RDIV;
      pend_div_q <= RDIV;
      pending_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef DIV_CLK_PROG_ODD_DUTY50_EN
  logic q_n_q, q_n_d;

  // Half-cycle delayed copy of the phase flop
  always_comb begin
    q_n_d = q_p;
  end

  // Negedge stage trims half a cycle off the odd high phase
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      q_n_q <= 1'b0;
    end else begin
      q_n_q <= q_n_d;
    end
  end

  assign div_clk = cur_div_q[0] ? (q_p & q_n_q) : q_p;
`else
  assign div_clk = q_p;
`endif

endmodule

// File: tb/tb_div_clk_prog.sv
// Scoreboard bench for div_clk_prog: period-level reference model,
// per-edge status queue and per-period length/high-time queue.
`timescale 1ns/1ps
module tb_div_clk_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, div_tick, div_clk;
  logic [7:0] cur_div;

  div_clk_prog #(.CNT_W(8), .DIV_DEFAULT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .cur_div(cur_div), .div_tick(div_tick),
    .div_clk(div_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int cur;
    bit rdy;
    bit err;
    bit tick;
  } st_t;

  st_t stq[$];
  int  perq[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: divisor in force, pending offer, period starts
  int m_n = 3, m_pn = 0, m_e = 0, m_last = 0;
  bit m_pend = 0, m_started = 0;

  function automatic void model();
    st_t s;
    bit  start, rdy_pre;
    s.rst = 0; s.err = 0; s.tick = 0;
    m_e++;
    if (!rst_n) begin
      m_n = 3; m_pend = 0; m_started = 0;
      perq.delete();
      s.rst = 1;
    end else begin
      start = !m_started || (m_e == m_last + m_n);
      rdy_pre = !m_pend;
      if (start) begin
        if (m_pend) begin
          m_n = m_pn;
          m_pend = 0;
        end
        m_started = 1;
        m_last = m_e;
        perq.push_back(m_n);
        s.tick = 1;
      end
      if (cfg_valid && rdy_pre) begin
        if (cfg_div < 2) s.err = 1;
        else begin
          m_pend = 1;
          m_pn = int'(cfg_div);
        end
      end
    end
    s.cur = m_n;
    s.rdy = !m_pend;
    stq.push_back(s);
  endfunction

  function automatic int exp_high(int n);
`ifdef DIV_CLK_PROG_ODD_DUTY50_EN
    return (n % 2 == 1) ? n * 5 : (n / 2) * 10;
`else
    return ((n + 1) / 2) * 10;
`endif
  endfunction

  // High-time capture on div_clk
  realtime rise_t = 0, high_ns = 0;
  int      rises = 0;
  always @(posedge div_clk) begin
    rise_t = $realtime;
    rises++;
  end
  always @(negedge div_clk) high_ns = $realtime - rise_t;

  // Monitor: per-edge status, and per-period checks on each tick
  int cyc = 0, prev_cyc = 0, exp_n, cur_r;
  bit have_prev = 0;
  st_t ms;
  realtime edge_t;
  always begin
    @(posedge clk);
    edge_t = $realtime;
    #2;
    cyc++;
    if (stq.size() > 0) begin
      ms = stq.pop_front();
      chk("cur_div", cur_div, ms.cur);
      chk("cfg_ready", cfg_ready, ms.rdy);
      chk("cfg_err", cfg_err, ms.err);
      chk("div_tick", div_tick, ms.tick);
      if (ms.rst) begin
        chk("div_clk_rst", div_clk, 0);
        have_prev = 0;
      end
    end
    if (div_tick === 1'b1) begin
      cur_r = (rise_t >= edge_t && rises > 0) ? 1 : 0;
      if (have_prev) begin
        if (perq.size() == 0) begin
          chk("period_queue", 0, 1);
        end else begin
          exp_n = perq.pop_front();
          chk("period_clks", cyc - prev_cyc, exp_n);
          chk("high_ns", longint'(high_ns), exp_high(exp_n));
          chk("rises", rises - cur_r, 1);
        end
      end
      rises = cur_r;
      prev_cyc = cyc;
      have_prev = 1;
    end
  end

  task automatic step(input bit r, input bit v, input int d);
    rst_n = r;
    cfg_valid = v;
    cfg_div = 8'(d);
    @(posedge clk);
    #1;
    model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic wait_pos(input int k);
    int b = 0;
    while (!(m_started && (m_e - m_last) == k) && b < 600) begin
      step(1, 0, 0);
      b++;
    end
    if (b >= 600) chk("wait_pos_timeout", b, 0);
  endtask

  task automatic wait_apply();
    int b = 0;
    while (m_pend && b < 600) begin
      step(1, 0, 0);
      b++;
    end
    if (b >= 600) chk("wait_apply_timeout", b, 0);
  endtask

  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    idle(25);
    // 4 accepted at cnt=1
    wait_pos(1);
    step(1, 1, 4);
    wait_apply();
    idle(20);
    // illegal divisors
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    idle(6);
    // 5 on the boundary edge, plus ignored offers while busy
    wait_pos(m_n - 1);
    step(1, 1, 5);
    step(1, 1, 9);
    step(1, 1, 9);
    step(1, 1, 1);
    wait_apply();
    idle(25);
    // largest divisor
    step(1, 1, 255);
    wait_apply();
    idle(530);
    // reset mid-high-phase with an offer pending
    step(1, 1, 6);
    wait_apply();
    idle(8);
    wait_pos(0);
    step(1, 1, 3);
    step(0, 0, 0);
    idle(20);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 10));
    end
    idle(30);
    @(posedge clk);
    #4;
    if (n_tests < 12) chk("too_few_tests", n_tests, 12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
